// File: rtl/la_ioring_seq_if.sv
// IO ring sequencer handshake bundle.
// Power request/ok in, ring control and busy out.
interface la_ioring_seq_if #(
  parameter int RINGW = 8
);
  logic             en;
  logic             pok;
  logic [RINGW-1:0] ioring;
  logic             busy;

  modport master (
    output en,
    output pok,
    input  ioring,
    input  busy
  );

  modport slave (
    input  en,
    input  pok,
    output ioring,
    output busy
  );
endinterface

// File: rtl/la_ioring_seq.sv
// IO ring power sequencer: OFF -> POR -> REL -> UNISO -> ON,
// with timed PWRDN back to OFF and pok-loss abort.
module la_ioring_seq #(
  parameter     PROP  = "DEFAULT",
  parameter int RINGW = 8,
  parameter int DELAY = 16
) (
  input  logic          clk,
  input  logic          reset,
  la_ioring_seq_if.slave io
);
  localparam int CW = (DELAY > 1) ? $clog2(DELAY + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DELAY - 1);

  typedef enum logic [2:0] {
    OFF, POR, REL, UNISO, ON, PWRDN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync_q, pok_s_q;
  logic [3:0]      ctl_q, ctl_d;
  logic            busy_q, busy_d;
  logic [RINGW-1:0] ring;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == OFF) begin
      cnt_d = '0;
      if (io.en && pok_s_q) begin
        state_d = POR;
        cnt_d   = LOAD;
      end
    end else if (!pok_s_q) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        POR, REL, UNISO: begin
          if (!io.en) begin
            state_d = PWRDN;
            cnt_d   = LOAD;
          end else if (cnt_q == '0) begin
            state_d = (state_q == POR) ? REL :
                      (state_q == REL) ? UNISO : ON;
            cnt_d   = (state_q == UNISO) ? '0 : LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ON: begin
          if (!io.en) begin
            state_d = PWRDN;
            cnt_d   = LOAD;
          end
        end
        PWRDN: begin
          if (cnt_q == '0) begin
            state_d = OFF;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from next state so they are registered with it
  always_comb begin
    ctl_d  = 4'b0010;
    busy_d = 1'b0;
    unique case (state_d)
      POR:     begin ctl_d = 4'b0010; busy_d = 1'b1; end
      REL:     begin ctl_d = 4'b0011; busy_d = 1'b1; end
      UNISO:   begin ctl_d = 4'b0001; busy_d = 1'b1; end
      ON:      begin ctl_d = 4'b1101; busy_d = 1'b0; end
      PWRDN:   begin ctl_d = 4'b0011; busy_d = 1'b1; end
      default: begin ctl_d = 4'b0010; busy_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OFF;
      cnt_q   <= '0;
      sync_q  <= 1'b0;
      pok_s_q <= 1'b0;
      ctl_q   <= 4'b0010;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= io.pok;
      pok_s_q <= sync_q;
      ctl_q   <= ctl_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    ring      = '0;
    ring[3:0] = ctl_q;
  end

  assign io.ioring = ring;
  assign io.busy   = busy_q;
endmodule

// File: tb/tb_la_ioring_seq.sv
// Bench for la_ioring_seq at DELAY=4 and DELAY=1,
// directed sequences then random en/pok against a timeline model.
module tb_la_ioring_seq;
  logic clk = 1'b0;
  logic reset;
  logic en, pok;

  always #5 clk = ~clk;

  la_ioring_seq_if #(.RINGW(8)) if0 ();
  la_ioring_seq_if #(.RINGW(8)) if1 ();

  assign if0.en  = en;
  assign if0.pok = pok;
  assign if1.en  = en;
  assign if1.pok = pok;

  la_ioring_seq #(.RINGW(8), .DELAY(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .io    (if0)
  );

  la_ioring_seq #(.RINGW(8), .DELAY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .io    (if1)
  );

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  // Phase: 0 OFF, 1 POR, 2 REL, 3 UNISO, 4 ON, 5 PWRDN
  // age = cycles already spent in the phase, counting the entry edge
  int ph[2], age[2], ms1[2], ms2[2];
  int dl[2] = '{4, 1};
  logic [7:0] exp_ring[6] = '{8'h02, 8'h02, 8'h03, 8'h01, 8'h0D, 8'h03};
  logic       exp_busy[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; age[i] = 0; ms1[i] = 0; ms2[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (ph[i] == 0) begin
        if (en && ms2[i] == 1) begin ph[i] = 1; age[i] = 1; end
      end else if (ms2[i] == 0) begin
        ph[i] = 0; age[i] = 0;
      end else if (ph[i] == 5) begin
        if (age[i] == dl[i]) begin ph[i] = 0; age[i] = 0; end
        else age[i]++;
      end else if (ph[i] == 4) begin
        if (!en) begin ph[i] = 5; age[i] = 1; end
      end else begin
        if (!en) begin ph[i] = 5; age[i] = 1; end
        else if (age[i] == dl[i]) begin ph[i]++; age[i] = 1; end
        else age[i]++;
      end
      ms2[i] = ms1[i];
      ms1[i] = int'(pok);
    end
  endtask

  task automatic model_cmp();
    check("m0_ring", if0.ioring, exp_ring[ph[0]]);
    check("m0_busy", 8'(if0.busy), 8'(exp_busy[ph[0]]));
    check("m1_ring", if1.ioring, exp_ring[ph[1]]);
    check("m1_busy", 8'(if1.busy), 8'(exp_busy[ph[1]]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_cmp();
  endtask

  task automatic chk0(string tag, logic [7:0] r, logic b);
    check({tag, "_ring"}, if0.ioring, r);
    check({tag, "_busy"}, 8'(if0.busy), 8'(b));
  endtask

  task automatic async_reset(string tag);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk0(tag, 8'h02, 1'b0);
    check({tag, "_d1"}, if1.ioring, 8'h02);
    check({tag, "_d1busy"}, 8'(if1.busy), 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    pok   = 1'b0;
    model_reset();
    #3;
    chk0("rst", 8'h02, 1'b0);
    check("rst_d1", if1.ioring, 8'h02);
    #9;
    reset = 1'b0;
    en    = 1'b1;
    pok   = 1'b1;

    // Power-up from reset release
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e <= 2)  chk0("presync", 8'h02, 1'b0);
      if (e == 3)  chk0("por", 8'h02, 1'b1);
      if (e == 6)  chk0("por_end", 8'h02, 1'b1);
      if (e == 7)  chk0("rel", 8'h03, 1'b1);
      if (e == 11) chk0("uniso", 8'h01, 1'b1);
      if (e == 14) chk0("uniso_end", 8'h01, 1'b1);
      if (e == 15) chk0("on", 8'h0D, 1'b0);
      if (e == 5)  check("d1_uniso", if1.ioring, 8'h01);
      if (e == 6)  check("d1_on", if1.ioring, 8'h0D);
    end

    // Drop en in ON
    en = 1'b0;
    tick(); chk0("pwrdn", 8'h03, 1'b1);
    repeat (3) begin tick(); chk0("pwrdn_hold", 8'h03, 1'b1); end
    tick(); chk0("pwrdn_off", 8'h02, 1'b0);

    // Drop pok in REL second cycle
    en = 1'b1;
    repeat (6) tick();
    chk0("rel2", 8'h03, 1'b1);
    pok = 1'b0;
    tick(); tick();
    chk0("pok_sync", 8'h03, 1'b1);
    tick(); chk0("pok_off", 8'h02, 1'b0);
    pok = 1'b1;
    tick(); tick();
    chk0("repok_wait", 8'h02, 1'b0);
    tick(); chk0("repor", 8'h02, 1'b1);
    repeat (3) begin tick(); chk0("repor_hold", 8'h02, 1'b1); end
    tick(); chk0("rerel", 8'h03, 1'b1);
    repeat (3) tick();
    tick(); chk0("reuniso", 8'h01, 1'b1);

    // One-cycle en drop in UNISO
    en = 1'b0;
    tick(); chk0("u_pwrdn", 8'h03, 1'b1);
    en = 1'b1;
    repeat (3) begin tick(); chk0("u_pwrdn_hold", 8'h03, 1'b1); end
    tick(); chk0("u_off", 8'h02, 1'b0);
    tick(); chk0("u_por", 8'h02, 1'b1);

    // Async reset in ON, then synchronizer latency with pok high
    repeat (12) tick();
    chk0("on2", 8'h0D, 1'b0);
    async_reset("areset");
    #3 reset = 1'b0;
    tick(); tick();
    chk0("post_rst", 8'h02, 1'b0);
    tick(); chk0("post_rst_por", 8'h02, 1'b1);

    // Random en/pok with occasional async reset
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) pok = ~pok;
      if ($urandom_range(0, 149) == 0) begin
        async_reset("rnd_rst");
        #2 reset = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/la_ioring_seq.md
LA_IORING_SEQ -- requirements
Module: la_ioring_seq

Interface
REQ-001 Parameter PROP, default "DEFAULT", cell property string passed through to implementation libraries.
REQ-002 Parameter RINGW, default 8, width of io ring control bus; SHALL be >= 4.
REQ-003 Parameter DELAY, default 16, clock cycles spent in each timed state; SHALL be >= 1.
REQ-004 clk  input  1  single sequencer clock.
REQ-005 reset  input  1  asynchronous active-high reset; one clock domain only.
REQ-006 en  input  1  synchronous power-up request; 1 = bring ring up, 0 = bring ring down.
REQ-007 pok  input  1  asynchronous io-supply power-ok from the vddio detector.
REQ-008 ioring  output  RINGW  generic ioring control bus consumed by the io pad/supply cells.
REQ-009 busy  output  1  high while in any timed state (POR, REL, UNISO, PWRDN).

Function
REQ-010 ioring bit map SHALL be: [0] porb (0 = pads held in power-on reset), [1] iso (1 = pads isolated), [2] oe (1 = pad output drivers enabled), [3] ready; bits [RINGW-1:4] SHALL be 0 constantly.
REQ-011 pok SHALL pass through a 2-flop synchronizer; pok_s is its output; FSM SHALL use only pok_s.
REQ-012 States SHALL be OFF, POR, REL, UNISO, ON, PWRDN, with outputs {porb,iso,oe,ready}: OFF 0,1,0,0; POR 0,1,0,0; REL 1,1,0,0; UNISO 1,0,0,0; ON 1,0,1,1; PWRDN 1,1,0,0.
REQ-013 All ioring bits and busy SHALL be registered (decoded from the state register, no input-to-output combinational path).
REQ-014 OFF -> POR when en=1 and pok_s=1; otherwise stay in OFF.
REQ-015 On entry to any timed state, the down-counter SHALL load DELAY-1 and decrement once per cycle; the state exits on the edge where the counter = 0, so each timed state lasts exactly DELAY cycles.
REQ-016 Timed exits SHALL be POR -> REL -> UNISO -> ON, and PWRDN -> OFF.
REQ-017 ON -> PWRDN when en=0; ON stays ON while en=1 and pok_s=1.
REQ-018 en=0 in POR, REL or UNISO SHALL go to PWRDN on the next edge, abandoning the count.
REQ-019 pok_s=0 in any state other than OFF SHALL go to OFF on the next edge. This takes priority over en and over timer expiry.
REQ-020 en=1 during PWRDN SHALL be ignored; the sequence completes to OFF and then re-evaluates.
REQ-021 Counter width SHALL be $clog2(DELAY+1), minimum 1 bit; the counter SHALL never wrap below 0.
REQ-022 Power-up latency: ioring[3] rises exactly 3*DELAY+3 edges after the first edge that samples pok=1 with en=1 held.

Reset
REQ-023 While reset=1, asynchronously: state=OFF, counter=0, both synchronizer flops=0, ioring={porb=0,iso=1,oe=0,ready=0,upper=0}, busy=0.
REQ-024 Reset asserted mid-sequence (any state) SHALL force the REQ-023 values immediately, without waiting for a clock edge.
REQ-025 After reset deasserts, the FSM SHALL need the full synchronizer latency before leaving OFF, even if pok is already high.

Verification (DELAY=4, RINGW=8)
REQ-026 reset released, en=1, pok=1 from edge 1:
- ioring=8'h02 through edge 2;
- POR from edge 3 (8'h02, busy=1);
- REL from edge 7 (8'h03);
- UNISO from edge 11 (8'h01);
- ON from edge 15 (8'h0D, busy=0).
REQ-027 In ON, drop en:
- next edge: ioring=8'h03, busy=1;
- 4 edges later: ioring=8'h02, busy=0, state OFF.
REQ-028 In REL (2nd cycle), drop pok:
- 2 edges later pok_s=0;
- next edge: ioring=8'h02, busy=0;
- re-raising pok restarts from POR, with full 4-cycle timing per state.
REQ-029 In UNISO, pulse en=0 for 1 cycle then en=1: PWRDN lasts 4 cycles, then OFF, then POR on the following edge.
REQ-030 Assert reset asynchronously (between edges) while in ON: ioring=8'h02 and busy=0 before the next clk edge.
REQ-031 DELAY=1 sweep: each timed state lasts exactly 1 cycle, ON reached 6 edges after pok first sampled; no counter underflow.
